// File: rtl/contador_pops_pkg.sv
// contador_pkg: shared state encodings and sizing constants for the pop counter block
package contador_pkg;
   typedef enum logic [3:0] {
      ST_RESET  = 4'b0001,
      ST_INIT   = 4'b0010,
      ST_IDLE   = 4'b0100,
      ST_ACTIVE = 4'b1000
   } state_e;
   localparam int CNT_W_DEF = 5;
   localparam int FIFOS     = 4;
endpackage

// File: rtl/contador_pops_if.sv
// contador_pops_if: counter-read bus between a requester and the pop counter block
interface contador_pops_if #(parameter int CNT_W = 5) ();
   logic             req;
   logic [1:0]       idx;
   logic             valid;
   logic [CNT_W-1:0] data_out;
   modport master (output req, output idx, input valid, input data_out);
   modport slave (input req, input idx, output valid, output data_out);
endinterface

// File: rtl/contador_pops_unit.sv
// contador_unit: one wrapping pop counter with clear priority over increment
module contador_unit import contador_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q;
   // clear wins over increment; increment wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (!reset_L) count_q <= '0;
      else if (clr) count_q <= '0;
      else if (inc) count_q <= count_q + 1'b1;
   end
   assign count = count_q;
endmodule

// File: rtl/contador_pops.sv
// contador_pops: four per-FIFO pop counters with a registered IDLE-only readout
module contador_pops import contador_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            reset_L,
   input  logic [3:0]      state,
   input  logic            pop_0,
   input  logic            pop_1,
   input  logic            pop_2,
   input  logic            pop_3,
   input  logic            empty_0,
   input  logic            empty_1,
   input  logic            empty_2,
   input  logic            empty_3,
   contador_pops_if.slave  bus
);
   logic [FIFOS-1:0] pop_eff;
   logic             one_hot;
   logic             clr;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt [FIFOS];
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] data_q, data_d;
   assign pop_eff = {pop_3 & ~empty_3, pop_2 & ~empty_2, pop_1 & ~empty_1, pop_0 & ~empty_0};
   assign one_hot = (state != '0) && ((state & (state - 4'd1)) == '0);
   assign clr     = state == ST_RESET;
   assign cnt_en  = one_hot && !clr;
   for (genvar g = 0; g < FIFOS; g++) begin : g_unit
      contador_unit #(.CNT_W(CNT_W)) u_unit (
         .clk     (clk),
         .reset_L (reset_L),
         .clr     (clr),
         .inc     (pop_eff[g] & cnt_en),
         .count   (cnt[g])
      );
   end
   // read accepted only in IDLE; otherwise data_out holds its last response
   always_comb begin
      valid_d = (state == ST_IDLE) && bus.req;
      data_d  = valid_d ? cnt[bus.idx] : data_q;
   end
   // response register gives the one-cycle read latency
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign bus.valid    = valid_q;
   assign bus.data_out = data_q;
endmodule

// File: tb/tb_contador_pops.sv
// tb_contador_pops: directed self-checking bench for the pop counter block
module tb_contador_pops;
   import contador_pkg::*;
   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic [3:0] state = ST_RESET;
   logic [3:0] pop = '0;
   logic [3:0] empty = '0;
   int         checks = 0;
   int         errors = 0;
   contador_pops_if #(.CNT_W(5)) bus ();
   contador_pops #(.CNT_W(5)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .state   (state),
      .pop_0   (pop[0]),
      .pop_1   (pop[1]),
      .pop_2   (pop[2]),
      .pop_3   (pop[3]),
      .empty_0 (empty[0]),
      .empty_1 (empty[1]),
      .empty_2 (empty[2]),
      .empty_3 (empty[3]),
      .bus     (bus)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse(input int f, input int n, input logic e);
      pop[f] = 1'b1;
      empty[f] = e;
      repeat (n) tick();
      pop[f] = 1'b0;
      empty[f] = 1'b0;
   endtask
   task automatic test_reset();
      reset_L = 1'b0;
      state = ST_INIT;
      pop = 4'hF;
      bus.req = 1'b1;
      bus.idx = 2'd0;
      repeat (2) tick();
      checks++;
      if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
      checks++;
      if (bus.data_out !== 5'd0) begin errors++; $display("FAIL reset_data got %0d want 0", bus.data_out); end
      pop = '0;
      bus.req = 1'b0;
      reset_L = 1'b1;
      state = ST_IDLE;
      for (int i = 0; i < 4; i++) begin
         bus.req = 1'b1;
         bus.idx = i[1:0];
         tick();
         checks++;
         if (bus.valid !== 1'b1 || bus.data_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_count%0d got valid=%b data=%0d want valid=1 data=0", i, bus.valid, bus.data_out);
         end
      end
      bus.req = 1'b0;
   endtask
   task automatic test_count_read();
      state = ST_INIT;
      pop[1] = 1'b1;
      pop[2] = 1'b1;
      repeat (3) tick();
      pop[2] = 1'b0;
      repeat (5) tick();
      pop[1] = 1'b0;
      state = ST_IDLE;
      bus.req = 1'b1;
      bus.idx = 2'd1;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd8) begin
         errors++;
         $display("FAIL read_idx1 got valid=%b data=%0d want valid=1 data=8", bus.valid, bus.data_out);
      end
      bus.idx = 2'd2;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd3) begin
         errors++;
         $display("FAIL read_idx2 got valid=%b data=%0d want valid=1 data=3", bus.valid, bus.data_out);
      end
      bus.req = 1'b0;
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.data_out !== 5'd3) begin
         errors++;
         $display("FAIL read_idle_hold got valid=%b data=%0d want valid=0 data=3", bus.valid, bus.data_out);
      end
   endtask
   task automatic test_empty_guard();
      state = ST_INIT;
      pulse(0, 5, 1'b1);
      state = ST_IDLE;
      bus.req = 1'b1;
      bus.idx = 2'd0;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd0) begin
         errors++;
         $display("FAIL empty_guard got valid=%b data=%0d want valid=1 data=0", bus.valid, bus.data_out);
      end
      bus.req = 1'b0;
   endtask
   task automatic test_wrap();
      state = ST_INIT;
      pulse(3, 33, 1'b0);
      state = ST_IDLE;
      bus.req = 1'b1;
      bus.idx = 2'd3;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd1) begin
         errors++;
         $display("FAIL wrap got valid=%b data=%0d want valid=1 data=1", bus.valid, bus.data_out);
      end
      bus.req = 1'b0;
   endtask
   task automatic test_gating();
      state = ST_ACTIVE;
      bus.req = 1'b1;
      bus.idx = 2'd1;
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.data_out !== 5'd1) begin
         errors++;
         $display("FAIL active_gate got valid=%b data=%0d want valid=0 data=1", bus.valid, bus.data_out);
      end
      state = 4'b0110;
      pop[1] = 1'b1;
      tick();
      pop[1] = 1'b0;
      checks++;
      if (bus.valid !== 1'b0) begin errors++; $display("FAIL bad_state_valid got %b want 0", bus.valid); end
      state = ST_IDLE;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd8) begin
         errors++;
         $display("FAIL bad_state_freeze got valid=%b data=%0d want valid=1 data=8", bus.valid, bus.data_out);
      end
      bus.req = 1'b0;
      state = ST_RESET;
      pop[1] = 1'b1;
      tick();
      pop[1] = 1'b0;
      state = ST_IDLE;
      bus.req = 1'b1;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd0) begin
         errors++;
         $display("FAIL state_clear1 got valid=%b data=%0d want valid=1 data=0", bus.valid, bus.data_out);
      end
      bus.idx = 2'd3;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd0) begin
         errors++;
         $display("FAIL state_clear3 got valid=%b data=%0d want valid=1 data=0", bus.valid, bus.data_out);
      end
      bus.req = 1'b0;
   endtask
   task automatic test_collision();
      state = ST_INIT;
      pulse(0, 4, 1'b0);
      state = ST_IDLE;
      bus.req = 1'b1;
      bus.idx = 2'd0;
      pop[0] = 1'b1;
      tick();
      pop[0] = 1'b0;
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd4) begin
         errors++;
         $display("FAIL collision_pre got valid=%b data=%0d want valid=1 data=4", bus.valid, bus.data_out);
      end
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.data_out !== 5'd5) begin
         errors++;
         $display("FAIL collision_post got valid=%b data=%0d want valid=1 data=5", bus.valid, bus.data_out);
      end
   endtask
   task automatic test_reset_mid_read();
      state = ST_IDLE;
      bus.req = 1'b1;
      bus.idx = 2'd0;
      reset_L = 1'b0;
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.data_out !== 5'd0) begin
         errors++;
         $display("FAIL reset_mid_read got valid=%b data=%0d want valid=0 data=0", bus.valid, bus.data_out);
      end
      reset_L = 1'b1;
      bus.req = 1'b0;
   endtask
   task automatic test_all_four();
      state = ST_INIT;
      pop = 4'hF;
      tick();
      pop = '0;
      state = ST_IDLE;
      for (int i = 0; i < 4; i++) begin
         bus.req = 1'b1;
         bus.idx = i[1:0];
         tick();
         checks++;
         if (bus.valid !== 1'b1 || bus.data_out !== 5'd1) begin
            errors++;
            $display("FAIL all_four%0d got valid=%b data=%0d want valid=1 data=1", i, bus.valid, bus.data_out);
         end
      end
      bus.req = 1'b0;
   endtask
   initial begin
      bus.req = 1'b0;
      bus.idx = 2'd0;
      test_reset();
      test_count_read();
      test_empty_guard();
      test_wrap();
      test_gating();
      test_collision();
      test_reset_mid_read();
      test_all_four();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/contador_pops.md
# contador_pops

Per-FIFO pop counter and readout responder for the transaction-layer FIFO bank. Four independent counters record how many words have been popped from FIFOs 0–3. When the main FSM is in IDLE, a requester reads any counter with the `req`/`idx` lines. The block answers with a registered `valid` and `data_out`. It is the responding end of the `req`/`idx`/`valid`/`data_out` counter-read interface.

## Interface
Parameters:
- `CNT_W`, 5: counter width and `data_out` width.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_L` in 1: synchronous, active-low reset.
- `state` in 4: one-hot main-FSM state. 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE.
- `pop_0`..`pop_3` in 1 each: pop strobe presented to FIFO i.
- `empty_0`..`empty_3` in 1 each: empty flag of FIFO i.
- `req` in 1: read request; level-sensitive and sampled every cycle.
- `idx` in 2: counter selected for the read.
- `valid` out 1: `data_out` holds a response this cycle.
- `data_out` out CNT_W: value of the selected counter.

## Operation
- Effective pop for FIFO i: `pop_i & ~empty_i`. A pop on an empty FIFO never counts.
- Counter i increments by 1 on every effective pop. Counting runs in INIT, IDLE and ACTIVE.
- Counters wrap modulo 2^CNT_W: 31 → 0 with CNT_W=5. There is no saturation and no overflow flag.
- `state` = RESET (0001) clears all counters to 0 on the next edge. The clear takes priority over a same-cycle pop.
- Any `state` value that is not one-hot freezes the counters and suppresses responses. This is a defensive rule.
- Reads are accepted only when `state` = IDLE (0100) and `req` = 1. The response appears on the next cycle.
- Reads are non-destructive; the counter keeps its value.
- `req` held high for N IDLE cycles gives N back-to-back responses. `idx` is sampled anew each cycle.
- `req` in any other state is ignored: `valid` = 0 and `data_out` holds its last value.

## Timing
- Reset (`reset_L`=0 at an edge): all counters = 0, `valid` = 0, `data_out` = 0. Reset overrides every other input.
- Reset asserted mid-read: `valid` drops to 0 on that edge, with no partial response.
- Read latency is 1 cycle. Request sampled at edge k gives `valid`=1 and `data_out`=count[idx] during the cycle after edge k.
- A read and an effective pop on the same counter in the same cycle return the pre-increment value. The increment is visible to a read issued the following cycle.
- Effective pops on all four FIFOs in one cycle increment all four counters independently.
- `valid` is a registered output and is never combinational from `req`.

## Structure
- Shared package `contador_pkg` holds:
  - the state encodings `ST_RESET`, `ST_INIT`, `ST_IDLE`, `ST_ACTIVE`;
  - the default `CNT_W`;
  - the FIFO count constant (4).
- Sub-module `contador_unit`: one wrapping counter with `clk`, `reset_L`, `clr`, `inc` and `count[CNT_W-1:0]`. It is instantiated four times.
- The top level contains the effective-pop gating, the state decode, and a registered 4:1 read mux that drives `valid` and `data_out`.

## Test plan
- Reset: hold `reset_L`=0 for 2 cycles with pops active → all counters 0, `valid`=0, `data_out`=0.
- Count and read: in INIT, 8 effective pops on FIFO 1 and 3 on FIFO 2. Then in IDLE, `req`=1 with `idx`=1 then `idx`=2 on consecutive cycles → responses 8 then 3, `valid`=1 for both cycles, 1-cycle latency.
- Empty guard: 5 pops on FIFO 0 while `empty_0`=1 → a later read of `idx`=0 returns 0.
- Wrap: 33 effective pops on FIFO 3 → a read of `idx`=3 returns 1.
- Gating: `req`=1 in ACTIVE → `valid` stays 0. Setting `state` = RESET then clears the counters, and reads in IDLE return 0.
- Collision: in IDLE, a read of `idx`=0 in the same cycle as a pop on FIFO 0 (counter = 4) → returns 4. A read the next cycle returns 5.
